// File: rtl/interp_mode_fsm_pkg.sv
// Shared definitions for the interpolation front-panel controller:
// the state encoding and the built-in mode indices.
package yoda_pkg;

  typedef enum logic [1:0] {
    ST_MODE_SEL = 2'd0,
    ST_POLY_SEL = 2'd1,
    ST_BUSY     = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  localparam int unsigned MODE_LIN    = 0;
  localparam int unsigned MODE_POLY   = 1;
  localparam int unsigned MODE_SPLINE = 2;

endpackage

// File: rtl/interp_mode_fsm_rise_detect.sv
// One-bit rising-edge detector; prev powers up high so a button held
// through reset never produces an edge.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= level_i;
  end

  assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/interp_mode_fsm.sv
// Front-panel control FSM: mode/degree selection, engine start/done
// handshake, busy watchdog and a timed or acknowledged DONE display.
module interp_mode_fsm
  import yoda_pkg::*;
#(
  parameter int unsigned NUM_MODES    = 3,
  parameter int unsigned POLY_MODE    = MODE_POLY,
  parameter int unsigned MAX_DEGREE   = 4,
  parameter int unsigned BUSY_TIMEOUT = 1_000_000,
  parameter int unsigned DONE_HOLD    = 50_000_000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            change_i,
  input  logic                            accept_i,
  input  logic                            back_i,
  input  logic                            eng_done_i,
  output logic [$clog2(NUM_MODES)-1:0]    mode_o,
  output logic [$clog2(MAX_DEGREE+1)-1:0] degree_o,
  output logic [1:0]                      state_o,
  output logic                            eng_start_o,
  output logic                            error_o
);

  localparam int MW = $clog2(NUM_MODES);
  localparam int DW = $clog2(MAX_DEGREE + 1);
  localparam int BW = $clog2(BUSY_TIMEOUT + 1);
  localparam int HW = $clog2(DONE_HOLD + 1);

  localparam logic [MW-1:0] ModeLast   = MW'(NUM_MODES - 1);
  localparam logic [MW-1:0] PolyIdx    = MW'(POLY_MODE);
  localparam logic [DW-1:0] DegreeLast = DW'(MAX_DEGREE);
  // Counters hold the number of completed cycles, so the exit cycle is at PARAM-1.
  localparam logic [BW-1:0] BusyLast   = BW'(BUSY_TIMEOUT - 1);
  localparam logic [HW-1:0] HoldLast   = HW'(DONE_HOLD - 1);

  logic changeRise, acceptRise, backRise;

  rise_detect u_change (.clk(clk), .rst(rst), .level_i(change_i), .rise_o(changeRise));
  rise_detect u_accept (.clk(clk), .rst(rst), .level_i(accept_i), .rise_o(acceptRise));
  rise_detect u_back   (.clk(clk), .rst(rst), .level_i(back_i),   .rise_o(backRise));

  state_e         state_q, state_d;
  logic [MW-1:0]  mode_q, mode_d;
  logic [DW-1:0]  degree_q, degree_d;
  logic           start_q, start_d;
  logic           error_q, error_d;
  logic [BW-1:0]  busyCnt_q, busyCnt_d;
  logic [HW-1:0]  doneCnt_q, doneCnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_MODE_SEL;
      mode_q    <= '0;
      degree_q  <= DW'(1);
      start_q   <= 1'b0;
      error_q   <= 1'b0;
      busyCnt_q <= '0;
      doneCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      degree_q  <= degree_d;
      start_q   <= start_d;
      error_q   <= error_d;
      busyCnt_q <= busyCnt_d;
      doneCnt_q <= doneCnt_d;
    end
  end

  // Button priority is back > accept > change; a losing edge is simply dropped.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    degree_d  = degree_q;
    start_d   = 1'b0;
    error_d   = error_q;
    busyCnt_d = busyCnt_q;
    doneCnt_d = doneCnt_q;

    case (state_q)
      ST_MODE_SEL: begin
        if (backRise) begin
          state_d = ST_MODE_SEL;
        end else if (acceptRise) begin
          if (mode_q == PolyIdx) begin
            state_d = ST_POLY_SEL;
          end else begin
            state_d = ST_BUSY;
            start_d = 1'b1;
            error_d = 1'b0;
          end
        end else if (changeRise) begin
          mode_d = (mode_q == ModeLast) ? '0 : mode_q + MW'(1);
        end
      end
      ST_POLY_SEL: begin
        if (backRise) begin
          state_d = ST_MODE_SEL;
        end else if (acceptRise) begin
          state_d = ST_BUSY;
          start_d = 1'b1;
          error_d = 1'b0;
        end else if (changeRise) begin
          degree_d = (degree_q == DegreeLast) ? DW'(1) : degree_q + DW'(1);
        end
      end
      ST_BUSY: begin
        if (backRise) begin
          state_d = ST_MODE_SEL;
          error_d = 1'b1;
        end else if (eng_done_i) begin
          state_d = ST_DONE;
        end else if (busyCnt_q == BusyLast) begin
          state_d = ST_DONE;
          error_d = 1'b1;
        end else begin
          busyCnt_d = busyCnt_q + BW'(1);
        end
      end
      ST_DONE: begin
        if (backRise || acceptRise || (doneCnt_q == HoldLast)) begin
          state_d = ST_MODE_SEL;
        end else begin
          doneCnt_d = doneCnt_q + HW'(1);
        end
      end
      default: state_d = ST_MODE_SEL;
    endcase

    if (state_d != state_q) begin
      busyCnt_d = '0;
      doneCnt_d = '0;
    end
  end

  assign mode_o      = mode_q;
  assign degree_o    = degree_q;
  assign state_o     = state_q;
  assign eng_start_o = start_q;
  assign error_o     = error_q;

endmodule

// File: tb/tb_interp_mode_fsm.sv
// Directed and randomized checks of interp_mode_fsm against a cycle-level
// behavioural model built from the panel's button and timing rules.
module tb_interp_mode_fsm;

  localparam int unsigned NM   = 3;
  localparam int unsigned PM   = 1;
  localparam int unsigned MAXD = 4;
  localparam int unsigned BTO  = 5;
  localparam int unsigned HOLD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic changeIn = 1'b0, acceptIn = 1'b0, backIn = 1'b0, doneIn = 1'b0;
  logic [1:0] modeOut;
  logic [2:0] degreeOut;
  logic [1:0] stateOut;
  logic       startOut, errorOut;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integers, counters count cycles spent in a state from 1.
  int mState = 0, mMode = 0, mDegree = 1, mStart = 0, mError = 0;
  int mBusyN = 0, mDoneN = 0;
  int prevC = 1, prevA = 1, prevB = 1;

  interp_mode_fsm #(
    .NUM_MODES(NM), .POLY_MODE(PM), .MAX_DEGREE(MAXD),
    .BUSY_TIMEOUT(BTO), .DONE_HOLD(HOLD)
  ) dut (
    .clk(clk), .rst(rst),
    .change_i(changeIn), .accept_i(acceptIn), .back_i(backIn), .eng_done_i(doneIn),
    .mode_o(modeOut), .degree_o(degreeOut), .state_o(stateOut),
    .eng_start_o(startOut), .error_o(errorOut)
  );

  always #5 clk = ~clk;

  task automatic enterState(input int s);
    mState = s;
    mBusyN = 1;
    mDoneN = 1;
  endtask

  task automatic modelStep(input int c, input int a, input int b, input int d, input int r);
    int rc, ra, rb;
    if (r != 0) begin
      mState = 0; mMode = 0; mDegree = 1; mStart = 0; mError = 0;
      mBusyN = 0; mDoneN = 0; prevC = 1; prevA = 1; prevB = 1;
      return;
    end
    rc = c & ~prevC & 1; ra = a & ~prevA & 1; rb = b & ~prevB & 1;
    prevC = c; prevA = a; prevB = b;
    mStart = 0;
    case (mState)
      0: if (rb == 0) begin
           if (ra != 0) begin
             if (mMode == PM) enterState(1);
             else begin enterState(2); mStart = 1; mError = 0; end
           end else if (rc != 0) mMode = (mMode + 1) % NM;
         end
      1: if (rb != 0) enterState(0);
         else if (ra != 0) begin enterState(2); mStart = 1; mError = 0; end
         else if (rc != 0) mDegree = (mDegree % MAXD) + 1;
      2: if (rb != 0) begin enterState(0); mError = 1; end
         else if (d != 0) enterState(3);
         else if (mBusyN == BTO) begin enterState(3); mError = 1; end
         else mBusyN++;
      default: if (rb != 0 || ra != 0 || mDoneN == HOLD) enterState(0);
               else mDoneN++;
    endcase
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("state", 32'(stateOut), 32'(mState));
    checkValue("mode", 32'(modeOut), 32'(mMode));
    checkValue("degree", 32'(degreeOut), 32'(mDegree));
    checkValue("start", 32'(startOut), 32'(mStart));
    checkValue("error", 32'(errorOut), 32'(mError));
  endtask

  task automatic applyStimulus(input int c, input int a, input int b, input int d, input int r);
    changeIn = c[0]; acceptIn = a[0]; backIn = b[0]; doneIn = d[0]; rst = r[0];
    modelStep(c, a, b, d, r);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic press(input int which);
    applyStimulus(which == 0, which == 1, which == 2, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
  endtask

  initial begin
    int modeSeq[3];
    int degSeq[5];
    modeSeq = '{2, 0, 1};
    degSeq  = '{2, 3, 4, 1, 2};

    // Reset with change held; releasing reset must not count as a press.
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1);
    checkValue("rst_state", 32'(stateOut), 0);
    checkValue("rst_degree", 32'(degreeOut), 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkValue("held_no_advance", 32'(modeOut), 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkValue("first_press", 32'(modeOut), 1);
    applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      press(0);
      checkValue("mode_wrap_seq", 32'(modeOut), 32'(modeSeq[i]));
    end

    // Poly sub-menu, degree wrap, then start with an immediate done.
    press(1);
    checkValue("poly_sel", 32'(stateOut), 1);
    for (int i = 0; i < 5; i++) begin
      press(0);
      checkValue("degree_seq", 32'(degreeOut), 32'(degSeq[i]));
    end
    applyStimulus(0, 1, 0, 0, 0);
    checkValue("start_pulse", 32'(startOut), 1);
    checkValue("busy_state", 32'(stateOut), 2);
    applyStimulus(0, 0, 0, 1, 0);
    checkValue("done_state", 32'(stateOut), 3);
    checkValue("done_no_error", 32'(errorOut), 0);
    for (int i = 0; i < int'(HOLD) - 1; i++) applyStimulus(0, 0, 0, 0, 0);
    checkValue("hold_last", 32'(stateOut), 3);
    applyStimulus(0, 0, 0, 0, 0);
    checkValue("hold_return", 32'(stateOut), 0);

    // Watchdog on a non-poly mode, then done exactly on the last allowed cycle.
    press(0);
    applyStimulus(0, 1, 0, 0, 0);
    for (int i = 0; i < int'(BTO) - 1; i++) applyStimulus(0, 0, 0, 0, 0);
    checkValue("busy_before_timeout", 32'(stateOut), 2);
    applyStimulus(0, 0, 0, 0, 0);
    checkValue("timeout_done", 32'(stateOut), 3);
    checkValue("timeout_error", 32'(errorOut), 1);
    press(2);
    applyStimulus(0, 1, 0, 0, 0);
    checkValue("error_cleared", 32'(errorOut), 0);
    for (int i = 0; i < int'(BTO) - 1; i++) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkValue("done_beats_timeout", 32'(errorOut), 0);
    press(2);

    // Accept and back together in POLY_SEL: back wins, no start.
    press(0);
    press(0);
    press(1);
    applyStimulus(0, 1, 1, 0, 0);
    checkValue("back_wins", 32'(stateOut), 0);
    checkValue("back_no_start", 32'(startOut), 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Reset in the middle of a run.
    press(1);
    press(1);
    applyStimulus(0, 0, 0, 0, 1);
    checkValue("midbusy_rst_state", 32'(stateOut), 0);
    checkValue("midbusy_rst_start", 32'(startOut), 0);
    applyStimulus(0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 4) == 0),
                    int'($urandom_range(0, 9) == 0), int'($urandom_range(0, 5) == 0),
                    int'($urandom_range(0, 199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interp_mode_fsm.md
# interp_mode_fsm

Parametrised front-panel control FSM for the interpolation engine. It generalises the fixed 3-mode selector to N modes with a configurable polynomial-degree sub-menu. It adds a start/done handshake to the engine, a busy watchdog and a timed or acknowledged DONE state. It sits between the debounced push-buttons and both the interpolation datapath and the seven-segment driver.

## Interface
- `NUM_MODES`, 3: number of selectable modes, ≥2; mode 0 = LIN, 1 = POLY, 2 = SPLINE, higher values are reserved for extensions.
- `POLY_MODE`, 1: mode index that opens the degree sub-menu.
- `MAX_DEGREE`, 4: highest polynomial degree, ≥2; degree range is 1..MAX_DEGREE.
- `BUSY_TIMEOUT`, 1_000_000: cycles allowed in BUSY before abort, ≥1.
- `DONE_HOLD`, 50_000_000: cycles DONE is shown before auto-return, ≥1.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `change_i` in 1: debounced level, "next option" button.
- `accept_i` in 1: debounced level, "confirm" button.
- `back_i` in 1: debounced level, "cancel" button.
- `eng_done_i` in 1: engine completion, single-cycle pulse.
- `mode_o` out clog2(NUM_MODES): current or locked mode.
- `degree_o` out clog2(MAX_DEGREE+1): current or locked degree.
- `state_o` out 2: MODE_SEL=0, POLY_SEL=1, BUSY=2, DONE=3.
- `eng_start_o` out 1: one-cycle start pulse to the engine.
- `error_o` out 1: last run hit the watchdog.

## Operation
- Button inputs pass through rising-edge detectors: edge = level & ~prev. `prev` resets to 1, so a button held through reset does not fire.
- Only edges act. Levels and held buttons are ignored after their first edge.
- Event priority within one cycle: back > accept > change. Lower-priority edges in the same cycle are discarded, not queued.
- **MODE_SEL:**
  - change: `mode_o` increments, wrapping from NUM_MODES-1 to 0.
  - accept with mode==POLY_MODE: go to POLY_SEL.
  - accept with any other mode: assert `eng_start_o`, clear `error_o`, go to BUSY.
  - back: no effect.
- **POLY_SEL:**
  - change: `degree_o` increments, wrapping from MAX_DEGREE to 1.
  - accept: assert `eng_start_o`, clear `error_o`, go to BUSY.
  - back: go to MODE_SEL. Mode and degree are retained.
- **BUSY:**
  - Buttons are ignored except back.
  - `eng_done_i`: go to DONE.
  - Watchdog reaches BUSY_TIMEOUT with no done: set `error_o`, go to DONE.
  - back: abort to MODE_SEL with `error_o`=1. No engine abort is signalled.
- **DONE:**
  - accept, back, or the hold counter reaching DONE_HOLD: go to MODE_SEL.
  - change: ignored.
- `eng_done_i` outside BUSY is ignored.
- `mode_o` and `degree_o` never change outside their own select states.

## Timing
- All outputs are registered.
- Reset values: state MODE_SEL, `mode_o`=0, `degree_o`=1, `eng_start_o`=0, `error_o`=0, counters 0, edge `prev`=1.
- Button latency:
  - Level rises before clock edge k; `prev` is low at k; update is visible after edge k.
  - That is one cycle from input to output.
- `eng_start_o` is high for exactly the first cycle in which `state_o`=BUSY.
- `eng_done_i` is honoured in any BUSY cycle, including the cycle where `eng_start_o`=1. DONE follows on the next edge.
- Watchdog:
  - Counts BUSY cycles starting from 1 on the first BUSY cycle.
  - Exit happens on the edge at which count==BUSY_TIMEOUT.
  - BUSY_TIMEOUT=1 therefore gives one BUSY cycle.
  - Simultaneous done and timeout: done wins, `error_o`=0.
- DONE hold counter uses the same counting rule. DONE lasts exactly DONE_HOLD cycles unless acknowledged earlier.
- Both counters clear on every state entry. Widths are clog2(param+1) and they never wrap.
- `rst` asserted in any state returns everything to reset values on the next edge. `eng_start_o` is never re-issued after reset.

## Structure
- Shared package `yoda_pkg`:
  - State encoding type and constants `ST_MODE_SEL`, `ST_POLY_SEL`, `ST_BUSY`, `ST_DONE`.
  - Mode constants `MODE_LIN`, `MODE_POLY`, `MODE_SPLINE`.
- Sub-module `rise_detect`:
  - One-bit edge detector with synchronous reset and reset value of `prev`=1.
  - Instantiated three times.
- A single next-state process plus registered outputs; no other hierarchy.

## Test plan
- Reset with `change_i` held high, then release and press once → no advance at release; `mode_o` goes 0→1 one cycle after the press edge.
- Four change presses in MODE_SEL with NUM_MODES=3 → `mode_o` sequence 1,2,0,1.
- Mode 1, accept → POLY_SEL. Five changes with MAX_DEGREE=4 → `degree_o` sequence 2,3,4,1,2. Accept → one-cycle `eng_start_o`, `state_o`=2.
- `eng_done_i` in the same cycle as `eng_start_o` → DONE next cycle, `error_o`=0. Idle → back to MODE_SEL after exactly DONE_HOLD cycles (use 8).
- BUSY_TIMEOUT=5 with no done → DONE after 5 BUSY cycles with `error_o`=1. A second run with done on cycle 5 → `error_o`=0.
- Accept and back edges in the same POLY_SEL cycle → MODE_SEL, no start. `rst` mid-BUSY → all outputs at reset values next cycle.
